// File: rtl/sae_search_engine_pkg.sv
// Shared types and width helpers for the motion-vector SAE search engine.
// Holds the FSM encoding and the derived-width functions.
package mv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_REF = 2'd1,
        SEARCH   = 2'd2,
        DONE     = 2'd3
    } state_t;

    function automatic int sae_w_f(input int pix_w, input int blk);
        return pix_w + 2 * $clog2(blk);
    endfunction

    function automatic int mv_w_f(input int range);
        return $clog2(2 * range);
    endfunction

    function automatic int cnt_w_f(input int mv_w);
        return 2 * mv_w + 1;
    endfunction

    function automatic int ncand_f(input int range);
        return (2 * range) * (2 * range);
    endfunction

    localparam int NCAND = ncand_f(4);

endpackage

// File: rtl/sae_search_engine_if.sv
// Pixel stream handshake between the GPIO input wrapper and the engine.
// A pixel moves when s_valid and s_ready are both high at a clock edge.
interface sae_search_engine_if #(
    parameter int PIX_W = 8
);
    logic             s_valid;
    logic [PIX_W-1:0] s_data;
    logic             s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sae_search_engine_sae_accum.sv
// Absolute-difference accumulator for one candidate block.
// sum is the value acc takes if the current pixel is accumulated.
module sae_accum #(
    parameter int PIX_W = 8,
    parameter int SAE_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             freeze,
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    output logic [SAE_W-1:0] acc,
    output logic [SAE_W-1:0] sum
);
    logic [PIX_W:0] diff;
    logic [PIX_W:0] absd;

    assign diff = {1'b0, pix_a} - {1'b0, pix_b};
    assign absd = diff[PIX_W] ? (~diff + 1'b1) : diff;
    assign sum  = acc + SAE_W'(absd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en && !freeze) begin
            acc <= sum;
        end
    end
endmodule

// File: rtl/sae_search_engine.sv
// Full-search block matcher: buffers a reference block, scores every
// candidate in the search window and reports the best motion vector.
module sae_search_engine
    import mv_pkg::*;
#(
    parameter  int PIX_W = 8,
    parameter  int BLK   = 4,
    parameter  int RANGE = 4,
    parameter  int MV_W  = mv_w_f(RANGE),
    localparam int SAE_W = sae_w_f(PIX_W, BLK),
    localparam int CNT_W = cnt_w_f(MV_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             early_term_en,
    sae_search_engine_if.slave pix,
    output logic             busy,
    output logic             done,
    output logic [SAE_W-1:0] min_sae,
    output logic [MV_W-1:0]  motion_vec_x,
    output logic [MV_W-1:0]  motion_vec_y,
    output logic [CNT_W-1:0] pruned_cnt
);
    localparam int NPIX = BLK * BLK;
    localparam int PC_W = $clog2(NPIX);
    localparam logic [PC_W-1:0] LAST_PIX = PC_W'(NPIX - 1);
    localparam logic [MV_W-1:0] LAST_POS = MV_W'(2 * RANGE - 1);
    localparam logic [MV_W-1:0] OFS      = MV_W'(RANGE);

    state_t state_q, state_d;

    logic [PIX_W-1:0] ref_buf [NPIX];
    logic [PC_W-1:0]  pix_cnt;
    logic [MV_W-1:0]  cx, cy;
    logic [MV_W-1:0]  best_x, best_y;
    logic [SAE_W-1:0] cur_min;
    logic [SAE_W-1:0] acc, sum;
    logic [CNT_W-1:0] prn_run;
    logic             et_q;
    logic             pruned_q;

    logic fire, go, ld_fire, sr_fire;
    logic last_pix, last_cand, cand_end;
    logic prune_now, pruned_eff, upd;

    assign busy        = (state_q == LOAD_REF) || (state_q == SEARCH);
    assign pix.s_ready = busy;
    assign done        = (state_q == DONE);

    assign fire      = pix.s_valid && busy;
    assign go        = (state_q == IDLE) && start;
    assign ld_fire   = fire && (state_q == LOAD_REF);
    assign sr_fire   = fire && (state_q == SEARCH);
    assign last_pix  = (pix_cnt == LAST_PIX);
    assign last_cand = (cx == LAST_POS) && (cy == LAST_POS);
    assign cand_end  = sr_fire && last_pix;

    // Pruning looks at the running sum before this pixel, never pixel 0.
    assign prune_now  = et_q && sr_fire && (pix_cnt != '0) && (acc > cur_min);
    assign pruned_eff = pruned_q || prune_now;
    assign upd        = !pruned_eff && (sum < cur_min);

    sae_accum #(
        .PIX_W (PIX_W),
        .SAE_W (SAE_W)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (go || cand_end),
        .en     (sr_fire),
        .freeze (pruned_eff),
        .pix_a  (pix.s_data),
        .pix_b  (ref_buf[pix_cnt]),
        .acc    (acc),
        .sum    (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = LOAD_REF;
            LOAD_REF: if (ld_fire && last_pix) state_d = SEARCH;
            SEARCH:   if (cand_end && last_cand) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ld_fire) ref_buf[pix_cnt] <= pix.s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt      <= '0;
            cx           <= '0;
            cy           <= '0;
            best_x       <= '0;
            best_y       <= '0;
            cur_min      <= '0;
            prn_run      <= '0;
            et_q         <= 1'b0;
            pruned_q     <= 1'b0;
            min_sae      <= '0;
            motion_vec_x <= '0;
            motion_vec_y <= '0;
            pruned_cnt   <= '0;
        end else if (go) begin
            pix_cnt  <= '0;
            cx       <= '0;
            cy       <= '0;
            best_x   <= '0;
            best_y   <= '0;
            cur_min  <= '1;
            prn_run  <= '0;
            et_q     <= early_term_en;
            pruned_q <= 1'b0;
        end else if (ld_fire) begin
            pix_cnt <= pix_cnt + 1'b1;
        end else if (sr_fire) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (prune_now) pruned_q <= 1'b1;
            if (last_pix) begin
                pruned_q <= 1'b0;
                cx       <= cx + 1'b1;
                if (cx == LAST_POS) cy <= cy + 1'b1;
                if (upd) begin
                    cur_min <= sum;
                    best_x  <= cx;
                    best_y  <= cy;
                end
                if (pruned_eff) prn_run <= prn_run + 1'b1;
                // Results publish as the FSM enters DONE.
                if (last_cand) begin
                    min_sae      <= upd ? sum : cur_min;
                    motion_vec_x <= (upd ? cx : best_x) - OFS;
                    motion_vec_y <= (upd ? cy : best_y) - OFS;
                    pruned_cnt   <= prn_run + CNT_W'(pruned_eff);
                end
            end
        end
    end
endmodule

// File: tb/tb_sae_search_engine.sv
// Randomised self-checking bench for sae_search_engine with a
// block-level reference model of the full search.
module tb_sae_search_engine;
    localparam int NPIX  = 16;
    localparam int NC    = 64;
    localparam int TOTAL = NPIX + NC * NPIX;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       early_term_en;
    logic       busy;
    logic       done;
    logic [11:0] min_sae;
    logic [2:0] motion_vec_x;
    logic [2:0] motion_vec_y;
    logic [6:0] pruned_cnt;

    sae_search_engine_if #(.PIX_W(8)) pix ();

    sae_search_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .early_term_en (early_term_en),
        .pix           (pix),
        .busy          (busy),
        .done          (done),
        .min_sae       (min_sae),
        .motion_vec_x  (motion_vec_x),
        .motion_vec_y  (motion_vec_y),
        .pruned_cnt    (pruned_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_acc = -2;

    int refp [NPIX];
    int cand [NC][NPIX];
    int exp_min, exp_x, exp_y, exp_pr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Whole-block search: exhaustive SAE with a prefix-sum pruning rule.
    task automatic model(input bit et);
        int cm, bc, s, part, d;
        cm = 4095;
        bc = 0;
        exp_pr = 0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            part = 0;
            for (int k = 0; k < NPIX; k++) begin
                d = cand[c][k] - refp[k];
                if (d < 0) d = -d;
                s += d;
                if (k < NPIX - 1) part = s;
            end
            if (et && part > cm) exp_pr++;
            else if (s < cm) begin
                cm = s;
                bc = c;
            end
        end
        exp_min = cm;
        exp_x = ((bc % 8) - 4) & 7;
        exp_y = ((bc / 8) - 4) & 7;
    endtask

    function automatic int pix_at(input int i);
        if (i < NPIX) return refp[i];
        return cand[(i - NPIX) / NPIX][(i - NPIX) % NPIX];
    endfunction

    task automatic drive(input int n, input int gap, input bit poke);
        for (int i = 0; i < n; i++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                pix.s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            pix.s_valid = 1'b1;
            pix.s_data  = 8'(pix_at(i));
            if (poke && i == 600) start = 1'b1;
            @(posedge clk);
            #1;
            last_acc = cyc;
            start = 1'b0;
        end
        pix.s_valid = 1'b0;
    endtask

    task automatic run_case(input string tag, input bit et,
                            input int gap, input bit poke);
        int d0;
        bit seen;
        model(et);
        early_term_en = et;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        drive(TOTAL, gap, poke);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!seen) chk({tag, "_done_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_done_lat"}, done_cyc, last_acc);
        chk({tag, "_min"}, int'(min_sae), exp_min);
        chk({tag, "_mvx"}, int'(motion_vec_x), exp_x);
        chk({tag, "_mvy"}, int'(motion_vec_y), exp_y);
        chk({tag, "_pruned"}, int'(pruned_cnt), exp_pr);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic fill(input int rv, input int cv);
        for (int k = 0; k < NPIX; k++) refp[k] = rv;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NPIX; k++) cand[c][k] = cv;
    endtask

    task automatic fill_rand(input int noise);
        for (int k = 0; k < NPIX; k++) refp[k] = int'($urandom_range(255));
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NPIX; k++) begin
                cand[c][k] = refp[k] + int'($urandom_range(noise));
                if (cand[c][k] > 255) cand[c][k] = 255;
            end
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        early_term_en = 1'b0;
        pix.s_valid = 1'b0;
        pix.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(pix.s_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_min", int'(min_sae), 0);
        chk("rst_mvx", int'(motion_vec_x), 0);
        chk("rst_mvy", int'(motion_vec_y), 0);
        chk("rst_pruned", int'(pruned_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill(100, 0);
        for (int k = 0; k < NPIX; k++) cand[42][k] = 100;
        early_term_en = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        drive(300, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(pix.s_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_nodone", done_cnt - d0, 0);
        chk("abort_min", int'(min_sae), 0);

        run_case("cand42", 1'b0, 0, 1'b0);
        fill(10, 20);
        run_case("tie", 1'b0, 0, 1'b0);
        fill(255, 0);
        run_case("max", 1'b0, 0, 1'b0);
        fill(50, 0);
        for (int k = 0; k < NPIX; k++) cand[0][k] = 50;
        run_case("et_on", 1'b1, 0, 1'b0);
        run_case("et_off", 1'b0, 0, 1'b0);

        fill(100, 0);
        for (int k = 0; k < NPIX; k++) cand[42][k] = 100;
        run_case("gaps", 1'b0, 30, 1'b1);

        for (int r = 0; r < 6; r++) begin
            fill_rand((r % 2 == 0) ? 40 : 255);
            run_case($sformatf("rnd%0d", r), 1'(r % 3 != 0),
                     int'($urandom_range(40)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
